// File: rtl/ram_port_arbiter_pkg.sv
// Shared widths, FSM encoding, access record and legality check for the RAM port arbiter.
package ram_port_arbiter_pkg;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] DEFAULT_ADDR_LIMIT = 64'd128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } access_t;

  // An access is legal only when word aligned and below the address window limit.
  function automatic logic access_legal(input logic [ADDR_W-1:0] addr,
                                        input logic [ADDR_W-1:0] limit);
    return (addr[1:0] == 2'b00) && (addr < limit);
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Requester-side handshake bundle; master = requester, slave = arbiter.
interface ram_port_arbiter_if;
  import ram_port_arbiter_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata, err);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata, err);

endinterface

// File: rtl/ram_arb_pick.sv
// Combinational winner selection between two requesters (round robin or port-0 priority).
module ram_arb_pick (
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  input  logic fixed_prio,
  output logic winner,
  output logic valid
);

  // When both ask, the port that was not granted last goes next unless port 0 is pinned.
  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = fixed_prio ? 1'b0 : ~last_grant;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Two-port arbiter/sequencer in front of a single-port 32-bit RAM, all outputs registered.
// Define RAM_ARB_FIXED_PRIO_EN to make port 0 win every contested arbitration.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter logic [ADDR_W-1:0] ADDR_LIMIT = DEFAULT_ADDR_LIMIT,
  parameter bit                RESET_PRIO = 1'b0
) (
  input  logic              CLK,
  input  logic              RESET,
  ram_port_arbiter_if.slave m0,
  ram_port_arbiter_if.slave m1,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  output logic              ram_write,
  output logic              ram_read,
  input  logic [DATA_W-1:0] ram_data_out
);

`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam logic FIXED_PRIO = 1'b1;
`else
  localparam logic FIXED_PRIO = 1'b0;
`endif

  arb_state_t        state_q;
  arb_state_t        state_d;
  logic              last_grant_q;
  logic              owner_q;
  logic              we_q;
  logic              legal_q;
  logic              pick_winner;
  logic              pick_valid;
  logic              take;
  logic              finish_read;
  logic              cand_legal;
  logic [1:0]        take_vec;
  access_t           cand;
  logic [1:0]        gnt_q;
  logic [1:0]        err_q;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

  ram_arb_pick u_pick (
    .req0       (m0.req),
    .req1       (m1.req),
    .last_grant (last_grant_q),
    .fixed_prio (FIXED_PRIO),
    .winner     (pick_winner),
    .valid      (pick_valid)
  );

  assign cand       = pick_winner ? {m1.we, m1.addr, m1.wdata} : {m0.we, m0.addr, m0.wdata};
  assign cand_legal = access_legal(cand.addr, ADDR_LIMIT);
  assign take_vec   = {take & pick_winner, take & ~pick_winner};

  always_comb begin
    state_d     = state_q;
    take        = 1'b0;
    finish_read = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          take    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE:   state_d = (legal_q && !we_q) ? RWAIT : IDLE;
      RWAIT: begin
        finish_read = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // The pointer holds the last-granted port; seeding it with the other port lets RESET_PRIO win first.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      last_grant_q <= ~RESET_PRIO;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      legal_q      <= 1'b0;
      ram_address  <= '0;
      ram_data_in  <= '0;
      ram_write    <= 1'b0;
      ram_read     <= 1'b0;
      gnt_q        <= '0;
      err_q        <= '0;
      rvalid_q     <= '0;
      rdata0_q     <= '0;
      rdata1_q     <= '0;
    end else begin
      gnt_q     <= take_vec;
      err_q     <= take_vec & {2{~cand_legal}};
      ram_write <= take & cand_legal & cand.we;
      ram_read  <= take & cand_legal & ~cand.we;
      rvalid_q  <= {finish_read & owner_q, finish_read & ~owner_q};
      if (finish_read && !owner_q) begin
        rdata0_q <= ram_data_out;
      end
      if (finish_read && owner_q) begin
        rdata1_q <= ram_data_out;
      end
      if (take) begin
        last_grant_q <= pick_winner;
        owner_q      <= pick_winner;
        we_q         <= cand.we;
        legal_q      <= cand_legal;
        ram_address  <= cand.addr;
        ram_data_in  <= cand.wdata;
      end
    end
  end

  assign m0.gnt    = gnt_q[0];
  assign m1.gnt    = gnt_q[1];
  assign m0.err    = err_q[0];
  assign m1.err    = err_q[1];
  assign m0.rvalid = rvalid_q[0];
  assign m1.rvalid = rvalid_q[1];
  assign m0.rdata  = rdata0_q;
  assign m1.rdata  = rdata1_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Self-checking bench for ram_port_arbiter: vector table, corner sequences and a randomized model run.
// Compile with RAM_ARB_FIXED_PRIO_EN to check the fixed-priority build.
module tb_ram_port_arbiter;

`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif
  localparam bit TB_RESET_PRIO = 1'b0;

  logic        CLK;
  logic        RESET;
  logic [63:0] ram_address;
  logic [31:0] ram_data_in;
  logic        ram_write;
  logic        ram_read;
  logic [31:0] ram_data_out;

  ram_port_arbiter_if m0_bus ();
  ram_port_arbiter_if m1_bus ();

  ram_port_arbiter #(.ADDR_LIMIT(64'd128), .RESET_PRIO(TB_RESET_PRIO)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .m0           (m0_bus),
    .m1           (m1_bus),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_write    (ram_write),
    .ram_read     (ram_read),
    .ram_data_out (ram_data_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int   vectors;
  int   miscompares;
  logic armed;
  logic preload;
  logic prev_strobe;

  function automatic logic [31:0] seed_word(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0301);
  endfunction

  // Registered-output RAM, 32 words, as seen by the SD host ADMA.
  logic [31:0] ram_mem [32];
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < 32; i++) ram_mem[i] <= seed_word(i);
      ram_data_out <= '0;
    end else begin
      if (ram_write) ram_mem[ram_address[6:2]] <= ram_data_in;
      if (ram_read)  ram_data_out <= ram_mem[ram_address[6:2]];
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (armed) begin
      checkOutput("strobe_exclusive", {63'd0, ram_write & ram_read}, 64'd0);
      checkOutput("strobe_spacing", {63'd0, prev_strobe & (ram_write | ram_read)}, 64'd0);
      prev_strobe = ram_write | ram_read;
    end
  end

  task automatic drive(input logic p, input logic req, input logic we,
                       input logic [63:0] addr, input logic [31:0] wdata);
    if (p) begin
      m1_bus.req = req; m1_bus.we = we; m1_bus.addr = addr; m1_bus.wdata = wdata;
    end else begin
      m0_bus.req = req; m0_bus.we = we; m0_bus.addr = addr; m0_bus.wdata = wdata;
    end
  endtask

  function automatic logic gnt_of(input logic p);
    return p ? m1_bus.gnt : m0_bus.gnt;
  endfunction
  function automatic logic err_of(input logic p);
    return p ? m1_bus.err : m0_bus.err;
  endfunction
  function automatic logic rvalid_of(input logic p);
    return p ? m1_bus.rvalid : m0_bus.rvalid;
  endfunction
  function automatic logic [31:0] rdata_of(input logic p);
    return p ? m1_bus.rdata : m0_bus.rdata;
  endfunction

  // One complete access on port p: hold req until gnt, then watch a 4-cycle window for rvalid.
  task automatic applyStimulus(input logic p, input logic we, input logic [63:0] addr, input logic [31:0] wdata,
                               output logic got_gnt, output logic got_err, output logic got_wr, output logic got_rd,
                               output logic [63:0] got_addr, output logic [31:0] got_din,
                               output int rv_count, output logic [31:0] got_rdata, output int rv_lat);
    got_gnt = 0; got_err = 0; got_wr = 0; got_rd = 0; got_addr = '0; got_din = '0;
    rv_count = 0; got_rdata = '0; rv_lat = -1;
    @(negedge CLK);
    drive(p, 1'b1, we, addr, wdata);
    for (int n = 0; n < 20 && !got_gnt; n++) begin
      @(negedge CLK);
      if (gnt_of(p)) begin
        got_gnt = 1; got_err = err_of(p); got_wr = ram_write; got_rd = ram_read;
        got_addr = ram_address; got_din = ram_data_in;
      end
    end
    drive(p, 1'b0, 1'b0, 64'd0, 32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLK);
      if (rvalid_of(p)) begin
        rv_count++;
        got_rdata = rdata_of(p);
        rv_lat = k;
      end
    end
  endtask

  typedef struct {
    logic        p;
    logic        we;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [12];

  // Randomized-phase model state.
  logic        pend [2];
  logic        tx_we [2];
  logic [63:0] tx_addr [2];
  logic [31:0] tx_wdata [2];
  int          hold [2];
  int          rv_at [2];
  logic [31:0] rv_data [2];
  logic [31:0] mem_m [32];

  task automatic newTx(input int p);
    int r;
    logic [63:0] a;
    r = $urandom_range(0, 9);
    if (r < 7)       a = {57'd0, 5'($urandom_range(0, 31)), 2'b00};
    else if (r == 7) a = {57'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(1, 3))};
    else if (r == 8) a = 64'd128 + 64'($urandom_range(0, 31)) * 64'd4;
    else             a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
    pend[p] = 1'b1;
    tx_we[p] = 1'($urandom_range(0, 1));
    tx_addr[p] = a;
    tx_wdata[p] = $urandom;
    drive(1'(p), 1'b1, tx_we[p], tx_addr[p], tx_wdata[p]);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic        g, e, wr, rd, legal, exp_err, exp_we;
    logic [63:0] ga;
    logic [31:0] gd, rdat;
    logic [1:0]  exp_g, exp_rv;
    int          rvn, lat, grants, first_at, rd_owner, now, free_at, last, w, exp_w;

    vectors = 0; miscompares = 0; armed = 0; prev_strobe = 0;
    RESET = 1'b1; preload = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 64'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 64'd0, 32'd0);
    repeat (2) @(negedge CLK);
    checkOutput("reset_gnt",    {62'd0, m1_bus.gnt, m0_bus.gnt}, 64'd0);
    checkOutput("reset_err",    {62'd0, m1_bus.err, m0_bus.err}, 64'd0);
    checkOutput("reset_rvalid", {62'd0, m1_bus.rvalid, m0_bus.rvalid}, 64'd0);
    checkOutput("reset_strobe", {62'd0, ram_write, ram_read}, 64'd0);
    checkOutput("reset_rdata",  {m1_bus.rdata, m0_bus.rdata}, 64'd0);
    checkOutput("reset_addr",   ram_address, 64'd0);
    checkOutput("reset_din",    {32'd0, ram_data_in}, 64'd0);
    armed = 1; preload = 0; RESET = 1'b0;

    $display("[TB] vector table");
    vecs[0]  = '{1'b0, 1'b1, 64'h40, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 64'h40, 32'h0, 1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b0, 1'b1, 64'h7C, 32'h12345678, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 64'h7C, 32'h0, 1'b0, 32'h12345678};
    vecs[4]  = '{1'b1, 1'b0, 64'h06, 32'h0, 1'b1, 32'h0};
    vecs[5]  = '{1'b0, 1'b1, 64'h80, 32'hBAD0BAD0, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 1'b1, 64'h1_0000_0000, 32'hBAD0BAD0, 1'b1, 32'h0};
    vecs[7]  = '{1'b1, 1'b0, 64'h00, 32'h0, 1'b0, seed_word(0)};
    vecs[8]  = '{1'b1, 1'b0, 64'h40, 32'h0, 1'b0, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 1'b0, 64'h7E, 32'h0, 1'b1, 32'h0};
    vecs[10] = '{1'b1, 1'b1, 64'h00, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[11] = '{1'b0, 1'b0, 64'h00, 32'h0, 1'b0, 32'hCAFEF00D};
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].p, vecs[i].we, vecs[i].addr, vecs[i].wdata, g, e, wr, rd, ga, gd, rvn, rdat, lat);
      checkOutput($sformatf("vec%0d_gnt", i),  {63'd0, g}, 64'd1);
      checkOutput($sformatf("vec%0d_err", i),  {63'd0, e}, {63'd0, vecs[i].exp_err});
      checkOutput($sformatf("vec%0d_ram_write", i), {63'd0, wr}, {63'd0, !vecs[i].exp_err && vecs[i].we});
      checkOutput($sformatf("vec%0d_ram_read", i),  {63'd0, rd}, {63'd0, !vecs[i].exp_err && !vecs[i].we});
      checkOutput($sformatf("vec%0d_addr", i), ga, vecs[i].addr);
      checkOutput($sformatf("vec%0d_din", i),  {32'd0, gd}, {32'd0, vecs[i].wdata});
      checkOutput($sformatf("vec%0d_rvalid_count", i), 64'(rvn), {63'd0, !vecs[i].exp_err && !vecs[i].we});
      if (!vecs[i].exp_err && !vecs[i].we) begin
        checkOutput($sformatf("vec%0d_rdata", i), {32'd0, rdat}, {32'd0, vecs[i].exp_rdata});
        checkOutput($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
      end
    end

    $display("[TB] both ports hold reads from reset");
    @(negedge CLK);
    RESET = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 64'h00, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 64'h04, 32'd0);
    @(negedge CLK);
    RESET = 1'b0;
    grants = 0; first_at = -1; rd_owner = 0;
    for (int c = 0; c < 24 && grants < 6; c++) begin
      @(negedge CLK);
      if (m0_bus.gnt || m1_bus.gnt) begin
        if (first_at < 0) first_at = c;
        checkOutput("both_single_gnt", {63'd0, m0_bus.gnt & m1_bus.gnt}, 64'd0);
        exp_w = FIXED ? 0 : ((grants % 2 == 0) ? int'(TB_RESET_PRIO) : 1 - int'(TB_RESET_PRIO));
        checkOutput("both_order", {63'd0, m1_bus.gnt}, 64'(exp_w));
        rd_owner = m1_bus.gnt ? 1 : 0;
        grants++;
      end
      if (m0_bus.rvalid || m1_bus.rvalid) begin
        checkOutput("both_rvalid_owner", {62'd0, m1_bus.rvalid, m0_bus.rvalid}, (rd_owner == 1) ? 64'd2 : 64'd1);
        checkOutput("both_rdata", {32'd0, rdata_of(1'(rd_owner))},
                    {32'd0, (rd_owner == 1) ? seed_word(1) : 32'hCAFEF00D});
      end
    end
    checkOutput("both_grant_count", 64'(grants), 64'd6);
    checkOutput("both_first_gnt_cycle", 64'(first_at), 64'd0);
    drive(1'b0, 1'b0, 1'b0, 64'd0, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 64'd0, 32'd0);
    repeat (4) @(negedge CLK);

    $display("[TB] reset during read wait");
    drive(1'b0, 1'b1, 1'b0, 64'h40, 32'd0);
    g = 0;
    for (int n = 0; n < 10 && !g; n++) begin
      @(negedge CLK);
      g = m0_bus.gnt;
    end
    checkOutput("rst_gnt_seen", {63'd0, g}, 64'd1);
    drive(1'b0, 1'b0, 1'b0, 64'd0, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    checkOutput("rst_no_rvalid", {63'd0, m0_bus.rvalid}, 64'd0);
    checkOutput("rst_rdata_clear", {32'd0, m0_bus.rdata}, 64'd0);
    checkOutput("rst_strobes", {62'd0, ram_write, ram_read}, 64'd0);
    RESET = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 64'h10, 32'h0BADF00D);
    @(negedge CLK);
    checkOutput("rst_regrant", {63'd0, m1_bus.gnt}, 64'd1);
    checkOutput("rst_regrant_write", {63'd0, ram_write}, 64'd1);
    checkOutput("rst_late_rvalid", {63'd0, m0_bus.rvalid}, 64'd0);
    drive(1'b1, 1'b0, 1'b0, 64'd0, 32'd0);

    $display("[TB] rejected write followed by legal request");
    @(negedge CLK);
    drive(1'b0, 1'b1, 1'b1, 64'h80, 32'h11111111);
    drive(1'b1, 1'b1, 1'b1, 64'h08, 32'h22222222);
    g = 0;
    for (int n = 0; n < 10 && !g; n++) begin
      @(negedge CLK);
      g = m0_bus.gnt | m1_bus.gnt;
    end
    checkOutput("err_gnt_m0", {62'd0, m1_bus.gnt, m0_bus.gnt}, 64'd1);
    checkOutput("err_pulse", {63'd0, m0_bus.err}, 64'd1);
    checkOutput("err_no_write", {63'd0, ram_write}, 64'd0);
    drive(1'b0, 1'b0, 1'b0, 64'd0, 32'd0);
    @(negedge CLK);
    checkOutput("err_gap", {63'd0, m1_bus.gnt}, 64'd0);
    checkOutput("err_single_cycle", {63'd0, m0_bus.err}, 64'd0);
    @(negedge CLK);
    checkOutput("err_next_gnt", {63'd0, m1_bus.gnt}, 64'd1);
    checkOutput("err_next_ok", {63'd0, m1_bus.err}, 64'd0);
    checkOutput("err_next_write", {63'd0, ram_write}, 64'd1);
    checkOutput("err_next_addr", ram_address, 64'h08);
    drive(1'b1, 1'b0, 1'b0, 64'd0, 32'd0);
    repeat (3) @(negedge CLK);

    $display("[TB] randomized run against reference model");
    RESET = 1'b1; preload = 1'b1;
    @(negedge CLK);
    RESET = 1'b0; preload = 1'b0;
    for (int i = 0; i < 32; i++) mem_m[i] = seed_word(i);
    for (int p = 0; p < 2; p++) begin
      pend[p] = 0; hold[p] = $urandom_range(0, 2); rv_at[p] = -1; rv_data[p] = '0;
      tx_we[p] = 0; tx_addr[p] = '0; tx_wdata[p] = '0;
    end
    now = 0; free_at = 1; last = -1;
    for (int t = 0; t < 1500; t++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p]) begin
          if (hold[p] > 0) hold[p]--;
          else newTx(p);
        end
      end
      @(negedge CLK);
      now++;
      // Arbiter is free once the previous access's slot has elapsed; requests seen at that edge compete.
      exp_g = 2'b00; w = 0;
      if (now >= free_at && (pend[0] || pend[1])) begin
        if (pend[0] && pend[1]) w = FIXED ? 0 : ((last < 0) ? int'(TB_RESET_PRIO) : 1 - last);
        else w = pend[1] ? 1 : 0;
        exp_g[w] = 1'b1;
      end
      legal   = (tx_addr[w][1:0] == 2'b00) && (tx_addr[w] < 64'd128);
      exp_we  = tx_we[w];
      exp_err = (exp_g != 2'b00) && !legal;
      checkOutput("rand_gnt", {62'd0, m1_bus.gnt, m0_bus.gnt}, {62'd0, exp_g});
      checkOutput("rand_err", {62'd0, m1_bus.err, m0_bus.err}, {62'd0, exp_g & {2{exp_err}}});
      checkOutput("rand_ram_write", {63'd0, ram_write}, {63'd0, (exp_g != 2'b00) && legal && exp_we});
      checkOutput("rand_ram_read",  {63'd0, ram_read},  {63'd0, (exp_g != 2'b00) && legal && !exp_we});
      if (exp_g != 2'b00) begin
        checkOutput("rand_addr", ram_address, tx_addr[w]);
        checkOutput("rand_din", {32'd0, ram_data_in}, {32'd0, tx_wdata[w]});
        last = w;
        free_at = now + ((legal && !exp_we) ? 3 : 2);
        if (legal && exp_we) mem_m[tx_addr[w][6:2]] = tx_wdata[w];
        if (legal && !exp_we) begin
          rv_at[w] = now + 2;
          rv_data[w] = mem_m[tx_addr[w][6:2]];
        end
        pend[w] = 1'b0;
        hold[w] = $urandom_range(0, 3);
        drive(1'(w), 1'b0, 1'b0, 64'd0, 32'd0);
      end
      exp_rv = {rv_at[1] == now, rv_at[0] == now};
      checkOutput("rand_rvalid", {62'd0, m1_bus.rvalid, m0_bus.rvalid}, {62'd0, exp_rv});
      for (int p = 0; p < 2; p++) begin
        if (exp_rv[p]) checkOutput("rand_rdata", {32'd0, rdata_of(1'(p))}, {32'd0, rv_data[p]});
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
